add12u_err_monitor: RTL and testbench
=====================================

# add12u_err_monitor

Streaming error-statistics collector that sits directly downstream of a 12-bit unsigned approximate adder. Each cycle it accepts one operand pair plus the approximate adder's 13-bit result, recomputes the exact sum, and accumulates the error metrics reported for each adder variant: absolute-error sum (MAE numerator), worst-case error (WCE) with its operands, and erroneous-sample count (EP numerator). A start/done sequencer bounds each characterisation run to a programmed sample count.

## Interface
Parameters:
- W, 12, operand width; the result width is W+1
- CNT_W, 24, sample-counter width; max run is 2^CNT_W−1 samples

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE or DONE only)
- num_samples  in  CNT_W  run length; sampled on accepted start
- in_valid  in  1  operand/result triple valid
- in_ready  out  1  block accepts this cycle
- a, b  in  W  operands applied to the adder
- o_approx  in  W+1  approximate adder output for a, b
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; statistics stable
- sample_cnt  out  CNT_W  samples accepted this run
- err_cnt  out  CNT_W  samples with o_approx ≠ a+b
- sum_abs_err  out  W+1+CNT_W  Σ|o_approx − (a+b)|
- max_abs_err  out  W+1  largest |error| seen
- max_a, max_b  out  W  operands producing max_abs_err

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch num_samples; clear all statistics and counters; go to RUN. Statistics from the previous run remain readable in DONE until that start.
- RUN: in_ready = 1 while sample_cnt < latched N; accept = in_valid & in_ready. When an accept makes sample_cnt == N, go to DRAIN next cycle. If N == 0, go to DRAIN immediately, accepting nothing.
- DRAIN: in_ready = 0; wait until the pipeline is empty (2 cycles); then go to DONE.
- start is ignored in RUN and DRAIN.
- Arithmetic: exact = a + b, zero-extended to W+1 bits. The error is computed W+2 bits wide and signed; |error| ≤ 2^(W+1)−1 fits in W+1 bits. The accumulator cannot overflow at the declared width, so no saturation.
- max update: strictly greater only; on a tie the first occurrence is retained.
- err_cnt increments when |error| ≠ 0.

## Timing
- Reset values: state IDLE; in_ready 0; busy 0; done 0; all statistics, counters and max_a/max_b 0.
- sample_cnt updates in the cycle after accept.
- Pipeline:
  - Stage 1 registers a, b, o_approx.
  - Stage 2 registers |error|.
  - Stage 3 updates sum_abs_err, err_cnt, max_*.
  - Statistics reflect an accepted sample 3 cycles after accept.
- done rises exactly when the last sample's statistics are visible.
- Back-to-back accepts at 1 sample/cycle with no bubbles.
- in_valid low in RUN stalls without penalty.
- rst mid-run: all state returns to IDLE on the next edge, in-flight samples are discarded, and statistics clear.
- start and rst in the same cycle: rst wins.

## Structure
- Shared package add12u_pkg: W, CNT_W defaults, state enum type, and a function abs_err(a, b, o) returning W+1 bits.
- One natural sub-module, add12u_err_datapath: the 3-stage pipeline and accumulators, driven by the accept and clear controls.
- The FSM and counters live in the top.

## Test plan
- Exact adder model (o_approx = a+b), N=1000 random samples → err_cnt 0, sum_abs_err 0, max_abs_err 0, sample_cnt 1000, done asserted.
- N=3 with a=0xFFF, b=0xFFF, o=0; then a=1, b=1, o=0; then a=0, b=0, o=0x1FFF → max_abs_err 8191 with max_a 0, max_b 0; sum 8190+2+8191=16383; err_cnt 3.
- Tie: two samples each with |err| 16, the first with a=5 → max_a stays 5.
- N=0 start → DRAIN then DONE, in_ready never high, all statistics 0.
- in_valid toggling 50% during N=10, then extra in_valid after the 10th accept → in_ready 0, sample_cnt stays 10.
- rst asserted 1 cycle after the 5th accept of N=8 → next cycle IDLE, all outputs 0.
- A new start from DONE → previous statistics clear the cycle after start.

Source files
------------

// File: rtl/add12u_pkg.sv
// Shared defaults, FSM state type and the absolute-error helper for the
// 12-bit approximate-adder error monitor.
package add12u_pkg;

  localparam int DEF_W     = 12;
  localparam int DEF_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // |o - (a+b)|; the difference is formed one bit wider than the result so the sign survives.
  function automatic logic [DEF_W:0] abs_err(
    input logic [DEF_W-1:0] a,
    input logic [DEF_W-1:0] b,
    input logic [DEF_W:0]   o
  );
    logic [DEF_W:0]          exact;
    logic signed [DEF_W+1:0] diff;
    exact = {1'b0, a} + {1'b0, b};
    diff  = $signed({1'b0, o}) - $signed({1'b0, exact});
    if (diff < 0) begin
      diff = -diff;
    end
    return diff[DEF_W:0];
  endfunction

endpackage

// File: rtl/add12u_err_datapath.sv
// Three-stage error pipeline: register inputs, register |error|, then fold into statistics.
// A sample accepted in cycle t is reflected in the statistics from cycle t+3; no backpressure.
module add12u_err_datapath
  import add12u_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 acc_i,
  input  logic [W-1:0]         a_i,
  input  logic [W-1:0]         b_i,
  input  logic [W:0]           o_i,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [W+CNT_W:0]     sum_abs_err_o,
  output logic [W:0]           max_abs_err_o,
  output logic [W-1:0]         max_a_o,
  output logic [W-1:0]         max_b_o
);

  logic             v1_q, v2_q;
  logic [W-1:0]     a1_q, b1_q, a2_q, b2_q;
  logic [W:0]       o1_q, ae2_q;

  logic [CNT_W-1:0] err_q, err_d;
  logic [W+CNT_W:0] sum_q, sum_d;
  logic [W:0]       max_q, max_d;
  logic [W-1:0]     maxa_q, maxa_d, maxb_q, maxb_d;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      o1_q  <= '0;
      v2_q  <= 1'b0;
      a2_q  <= '0;
      b2_q  <= '0;
      ae2_q <= '0;
    end else begin
      v1_q <= acc_i;
      if (acc_i) begin
        a1_q <= a_i;
        b1_q <= b_i;
        o1_q <= o_i;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        a2_q  <= a1_q;
        b2_q  <= b1_q;
        ae2_q <= abs_err(a1_q, b1_q, o1_q);
      end
    end
  end

  // Strictly-greater compare keeps the first occurrence of a tied maximum.
  always_comb begin
    err_d  = err_q;
    sum_d  = sum_q;
    max_d  = max_q;
    maxa_d = maxa_q;
    maxb_d = maxb_q;
    if (v2_q) begin
      sum_d = sum_q + {{CNT_W{1'b0}}, ae2_q};
      if (ae2_q != '0) begin
        err_d = err_q + CNT_W'(1);
      end
      if (ae2_q > max_q) begin
        max_d  = ae2_q;
        maxa_d = a2_q;
        maxb_d = b2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      err_q  <= '0;
      sum_q  <= '0;
      max_q  <= '0;
      maxa_q <= '0;
      maxb_q <= '0;
    end else begin
      err_q  <= err_d;
      sum_q  <= sum_d;
      max_q  <= max_d;
      maxa_q <= maxa_d;
      maxb_q <= maxb_d;
    end
  end

  assign err_cnt_o     = err_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;
  assign max_a_o       = maxa_q;
  assign max_b_o       = maxb_q;

endmodule

// File: rtl/add12u_err_monitor.sv
// Error-statistics collector for a 12-bit approximate adder; start/done bounded runs of N samples.
// Stats lag accept by 3 cycles; in_ready drops once N samples are taken and outside RUN.
module add12u_err_monitor
  import add12u_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W:0]        o_approx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [W+CNT_W:0]  sum_abs_err,
  output logic [W:0]        max_abs_err,
  output logic [W-1:0]      max_a,
  output logic [W-1:0]      max_b
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic             start_acc;
  logic             accept;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_ready  = (state_q == ST_RUN) && (cnt_q < n_q);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    drain_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          n_d     = num_samples;
          cnt_d   = '0;
          state_d = (num_samples == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == n_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Two drain cycles cover pipeline stages 2 and 3 of the last sample.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign sample_cnt = cnt_q;

  add12u_err_datapath #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (start_acc),
    .acc_i         (accept),
    .a_i           (a),
    .b_i           (b),
    .o_i           (o_approx),
    .err_cnt_o     (err_cnt),
    .sum_abs_err_o (sum_abs_err),
    .max_abs_err_o (max_abs_err),
    .max_a_o       (max_a),
    .max_b_o       (max_b)
  );

endmodule

// File: tb/tb_add12u_err_monitor.sv
// Directed bench for add12u_err_monitor with hand-computed expectations.
module tb_add12u_err_monitor;

  localparam int W     = 12;
  localparam int CNT_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      a = '0;
  logic [W-1:0]      b = '0;
  logic [W:0]        o_approx = '0;
  logic              busy, done;
  logic [CNT_W-1:0]  sample_cnt, err_cnt;
  logic [W+CNT_W:0]  sum_abs_err;
  logic [W:0]        max_abs_err;
  logic [W-1:0]      max_a, max_b;

  int tests = 0;
  int fails = 0;

  add12u_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .o_approx(o_approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .max_a(max_a), .max_b(max_b)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_samples = n;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W:0] to);
    int g;
    g = 0;
    a = ta; b = tb; o_approx = to; in_valid = 1'b1;
    while (!in_ready && g < 20) begin
      step();
      g++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL feed_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int g;
    g = 0;
    while (done !== 1'b1 && g < budget) begin
      step();
      g++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b not seen within %0d cycles", done, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    tests++;
    if ({in_ready, busy, done} !== 3'b000 || sample_cnt !== 0 || err_cnt !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0 || max_a !== 0 || max_b !== 0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d required all 0",
               in_ready, busy, done, sample_cnt, err_cnt, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_exact_back_to_back();
    logic [W-1:0] ra, rb;
    do_start(24'd1000);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 4095));
      rb = W'($urandom_range(0, 4095));
      feed(ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    // Exactly 2 drain cycles after the last accept, no bubbles while feeding.
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL exact_drain1: busy=%b done=%b rdy=%b required 1 0 0", busy, done, in_ready);
    end
    step(); step();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL exact_done_timing: done=%b required 1", done);
    end
    tests++;
    if (err_cnt !== 0 || sum_abs_err !== 0 || max_abs_err !== 0 || sample_cnt !== 24'd1000) begin
      fails++;
      $display("FAIL exact_stats: err=%0d sum=%0d max=%0d cnt=%0d required 0 0 0 1000",
               err_cnt, sum_abs_err, max_abs_err, sample_cnt);
    end
  endtask

  task automatic test_extremes();
    do_start(24'd3);
    feed(12'hFFF, 12'hFFF, 13'h0000);
    feed(12'h001, 12'h001, 13'h0000);
    feed(12'h000, 12'h000, 13'h1FFF);
    step();
    tests++;
    if (done !== 1'b0 || sum_abs_err !== 37'd8192 || max_abs_err !== 13'd8190 || max_a !== 12'hFFF) begin
      fails++;
      $display("FAIL extremes_latency: done=%b sum=%0d max=%0d max_a=%h required 0 8192 8190 fff",
               done, sum_abs_err, max_abs_err, max_a);
    end
    step();
    tests++;
    if (done !== 1'b1 || sum_abs_err !== 37'd16383 || err_cnt !== 24'd3 ||
        max_abs_err !== 13'd8191 || max_a !== 12'h000 || max_b !== 12'h000) begin
      fails++;
      $display("FAIL extremes_stats: done=%b sum=%0d err=%0d max=%0d a=%h b=%h required 1 16383 3 8191 0 0",
               done, sum_abs_err, err_cnt, max_abs_err, max_a, max_b);
    end
  endtask

  task automatic test_restart_clears();
    do_start(24'd2);
    tests++;
    if (sum_abs_err !== 0 || err_cnt !== 0 || max_abs_err !== 0 || max_a !== 0 ||
        sample_cnt !== 0 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: sum=%0d err=%0d max=%0d cnt=%0d done=%b busy=%b required 0 0 0 0 0 1",
               sum_abs_err, err_cnt, max_abs_err, sample_cnt, done, busy);
    end
  endtask

  task automatic test_tie();
    // Continues the N=2 run opened by test_restart_clears.
    feed(12'd5, 12'd3, 13'd24);
    feed(12'd10, 12'd6, 13'd0);
    wait_done(10);
    tests++;
    if (max_abs_err !== 13'd16 || max_a !== 12'd5 || max_b !== 12'd3 ||
        sum_abs_err !== 37'd32 || err_cnt !== 24'd2) begin
      fails++;
      $display("FAIL tie_first_kept: max=%0d a=%0d b=%0d sum=%0d err=%0d required 16 5 3 32 2",
               max_abs_err, max_a, max_b, sum_abs_err, err_cnt);
    end
  endtask

  task automatic test_zero_run();
    int rdy_seen;
    rdy_seen = 0;
    in_valid = 1'b1;
    do_start(24'd0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_busy: busy=%b required 1", busy);
    end
    for (int i = 0; i < 6 && done !== 1'b1; i++) begin
      if (in_ready) rdy_seen++;
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || rdy_seen !== 0 || sample_cnt !== 0 || sum_abs_err !== 0 ||
        err_cnt !== 0 || max_abs_err !== 0) begin
      fails++;
      $display("FAIL zero_run: done=%b rdy_cycles=%0d cnt=%0d sum=%0d err=%0d required 1 0 0 0 0",
               done, rdy_seen, sample_cnt, sum_abs_err, err_cnt);
    end
  endtask

  task automatic test_valid_toggle();
    int acc, g;
    acc = 0;
    g = 0;
    do_start(24'd10);
    while (acc < 10 && g < 100) begin
      in_valid = (g % 2 == 0);
      a = W'(acc + 1);
      b = W'(acc + 1);
      o_approx = (W+1)'(2 * (acc + 1) + 1);
      if (in_valid && in_ready) acc++;
      step();
      g++;
    end
    tests++;
    if (acc !== 10) begin
      fails++;
      $display("FAIL toggle_accepts: accepted=%0d required 10", acc);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (in_ready !== 1'b0 || sample_cnt !== 24'd10) begin
        fails++;
        $display("FAIL toggle_overrun: rdy=%b cnt=%0d required 0 10", in_ready, sample_cnt);
      end
      step();
    end
    wait_done(10);
    in_valid = 1'b0;
    tests++;
    if (sample_cnt !== 24'd10 || err_cnt !== 24'd10 || sum_abs_err !== 37'd10 || max_abs_err !== 13'd1 ||
        max_a !== 12'd1) begin
      fails++;
      $display("FAIL toggle_stats: cnt=%0d err=%0d sum=%0d max=%0d a=%0d required 10 10 10 1 1",
               sample_cnt, err_cnt, sum_abs_err, max_abs_err, max_a);
    end
  endtask

  task automatic test_midrun_reset();
    do_start(24'd8);
    for (int i = 0; i < 5; i++) begin
      feed(W'(i + 1), 12'd2, 13'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({in_ready, busy, done} !== 3'b000 || sample_cnt !== 0 || err_cnt !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0 || max_a !== 0 || max_b !== 0) begin
      fails++;
      $display("FAIL midrun_reset: rdy=%b busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d required all 0",
               in_ready, busy, done, sample_cnt, err_cnt, sum_abs_err, max_abs_err);
    end
    step(); step(); step();
    tests++;
    if (sum_abs_err !== 0 || err_cnt !== 0 || max_abs_err !== 0) begin
      fails++;
      $display("FAIL midrun_flush: sum=%0d err=%0d max=%0d required 0 0 0", sum_abs_err, err_cnt, max_abs_err);
    end
  endtask

  task automatic test_start_with_reset();
    rst = 1'b1;
    do_start(24'd4);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_vs_rst: busy=%b rdy=%b required 0 0", busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_exact_back_to_back();
    test_extremes();
    test_restart_clears();
    test_tie();
    test_zero_run();
    test_valid_toggle();
    test_midrun_reset();
    test_start_with_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
